// File: rtl/bias_add_stream.sv
// bias_add_stream: runtime-loadable bias bank added lane-wise to a streaming
// adder-tree result vector. Two-stage pipeline: stage 1 adds the selected
// group's biases at full W+1 precision, stage 2 saturates back to W bits,
// applies optional ReLU and feeds the sticky saturation flag.
module bias_add_stream #(
  parameter int N_adder_tree = 16,
  parameter int W            = 18,
  parameter int DEPTH        = 64,
  parameter int AW           = $clog2(DEPTH),
  parameter int LW           = $clog2(N_adder_tree)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [AW-1:0]             cfg_addr,
  input  logic [LW-1:0]             cfg_lane,
  input  logic [W-1:0]              cfg_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_adder_tree*W-1:0] in_data,
  input  logic [AW-1:0]             in_group,
  input  logic                      in_relu,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_adder_tree*W-1:0] out_data,
  output logic                      sat_flag,
  input  logic                      sat_clr
);

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  // Clamp a W+1 bit sum into the W-bit signed range.
  function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] s);
    if (s[W] != s[W-1]) begin
      return s[W] ? SAT_MIN : SAT_MAX;
    end
    return s[W-1:0];
  endfunction

  // True when the W+1 bit sum does not fit into W bits.
  function automatic logic ovf_w(input logic signed [W:0] s);
    return s[W] ^ s[W-1];
  endfunction

  // Optional ReLU on an already saturated lane.
  function automatic logic signed [W-1:0] relu_w(input logic signed [W-1:0] x,
                                                 input logic relu);
    if (relu && x[W-1]) begin
      return '0;
    end
    return x;
  endfunction

  logic                      en;
  logic                      vld_p1;
  logic                      vld_p2;
  logic                      relu_p1;
  logic signed [W:0]         sum_p1 [N_adder_tree];
  logic [N_adder_tree*W-1:0] data_p2;

  logic signed [W-1:0]       bias_mem [DEPTH][N_adder_tree];
  logic signed [W:0]         sum_d [N_adder_tree];
  logic [N_adder_tree*W-1:0] res_d;
  logic                      ovf_d;
  logic                      wr_ok;
  logic                      grp_ok;

  // A stalled output holds the whole pipeline; bubbles are not collapsed.
  assign en        = out_ready | ~vld_p2;
  assign in_ready  = en;
  assign out_valid = vld_p2;
  assign out_data  = data_p2;

  assign wr_ok  = cfg_we && (int'(cfg_addr) < DEPTH) && (int'(cfg_lane) < N_adder_tree);
  assign grp_ok = int'(in_group) < DEPTH;

  // Bias bank: cleared by reset, written one lane per cycle. A write landing
  // on the same edge as an acceptance is not seen by that vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int g = 0; g < DEPTH; g++) begin
        for (int l = 0; l < N_adder_tree; l++) begin
          bias_mem[g][l] <= '0;
        end
      end
    end else if (wr_ok) begin
      bias_mem[cfg_addr][cfg_lane] <= cfg_data;
    end
  end

  // Stage 1 adder: sign-extend both operands so the sum cannot wrap.
  always_comb begin
    for (int i = 0; i < N_adder_tree; i++) begin
      logic [W-1:0] lane;
      logic [W-1:0] b;
      lane     = in_data[W*i +: W];
      b        = grp_ok ? bias_mem[in_group][i] : '0;
      sum_d[i] = $signed({lane[W-1], lane}) + $signed({b[W-1], b});
    end
  end

  // ---- stage 1 boundary: input -> p1 ----
  // Stage 1 valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p1 <= in_valid;
    end
  end

  // Stage 1 data capture on acceptance only.
  always_ff @(posedge clk) begin
    if (en && in_valid) begin
      sum_p1  <= sum_d;
      relu_p1 <= in_relu;
    end
  end

  // Stage 2 datapath: saturate, then ReLU; overflow is judged before ReLU.
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    for (int i = 0; i < N_adder_tree; i++) begin
      res_d[W*i +: W] = relu_w(sat_w(sum_p1[i]), relu_p1);
      ovf_d           = ovf_d | ovf_w(sum_p1[i]);
    end
  end

  // ---- stage 2 boundary: p1 -> p2 (output) ----
  // Output register, cleared by reset so out_data reads zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else if (en) begin
      vld_p2  <= vld_p1;
      data_p2 <= res_d;
    end
  end

  // Sticky saturation flag; a new saturation beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (en && vld_p1 && ovf_d) begin
      sat_flag <= 1'b1;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end
  end

endmodule

// File: doc/bias_add_stream.md
Name: bias_add_stream

Overview:
- Parametrised successor to the per-layer constant bias banks.
- A runtime-loadable bias bank holds DEPTH groups of N_adder_tree 18-bit signed biases.
- Adds the selected group's biases lane-wise to a streaming adder-tree result vector, with saturation, optional ReLU and a sticky saturation flag.
- Sits between the adder-tree outputs and the activation/output buffer, so one instance serves every layer instead of one hard-coded bias module per layer.

Parameters:
- N_adder_tree, 16, number of parallel lanes.
- W, 18, lane width in bits; signed two's complement for data and bias.
- DEPTH, 64, number of bias groups (output-channel groups) stored.
- AW, $clog2(DEPTH), group address width.
- LW, $clog2(N_adder_tree), lane index width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cfg_we  input  1  bias write strobe.
- cfg_addr  input  AW  bias group to write.
- cfg_lane  input  LW  lane within group to write.
- cfg_data  input  W  signed bias value.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept input this cycle.
- in_data  input  N_adder_tree*W  lane i at bits [W*(i+1)-1:W*i].
- in_group  input  AW  bias group applied to this vector.
- in_relu  input  1  apply ReLU to this vector.
- out_valid  output  1  output vector valid.
- out_ready  input  1  downstream accepts output.
- out_data  output  N_adder_tree*W  biased result, same lane packing.
- sat_flag  output  1  sticky: some lane saturated since last clear.
- sat_clr  input  1  clears sat_flag.

Behaviour:
- Reset (rst_n=0 at clock edge):
  - All bias entries set to 0.
  - Both pipeline valid bits cleared; out_valid=0, out_data=0.
  - sat_flag=0.
  - in_ready=1 in the cycle after reset.
- Bias write: on cfg_we=1, entry [cfg_addr][cfg_lane] <= cfg_data at the clock edge. The new value is visible to input vectors accepted from the next cycle on.
- Write/read collision: a write and an input acceptance in the same cycle targeting the same group/lane → the accepted vector uses the OLD bias.
- Writes are legal at any time, including mid-stream. Out-of-range cfg_addr (>=DEPTH) is ignored.
- Pipeline: 2 stages, global enable en = out_ready | ~out_valid; in_ready = en.
  - Stage 1, on en & in_valid:
    - per lane, 19-bit sum s1[i] = sext(in_data[i]) + sext(bias[in_group][i]);
    - in_relu is registered alongside;
    - s1_valid <= in_valid whenever en=1.
  - Stage 2, on en:
    - per lane, saturate s1[i] to W bits: >2^(W-1)-1 → 2^(W-1)-1 (131071); <-2^(W-1) → -2^(W-1) (-131072);
    - then, if relu=1 and the result is negative, the result is 0;
    - out_valid <= s1_valid.
- Latency: exactly 2 cycles from acceptance (in_valid & in_ready) to out_valid when out_ready is held 1. Throughput is one vector per cycle.
- Backpressure: while out_valid=1 & out_ready=0, both stages hold. out_data is stable, in_ready=0, and no input is accepted. Bubbles are not collapsed.
- sat_flag:
  - set at the stage-2 update when any lane of a valid vector saturated (before ReLU);
  - sat_clr=1 clears it;
  - simultaneous set and clear → flag set (set wins).
- Reset mid-stream: in-flight vectors are discarded and bias contents are zeroed. Reset has priority over cfg_we and the handshakes.
- No combinational path from out_ready to out_data. The in_ready ← out_ready combinational path is permitted.

Test Plan:
1. Reset, then load group 3 with lane0=-1484, lane1=892, other lanes 0. Send in_data lane0=1000, lane1=-892, group 3, relu=0, out_ready=1 → out_valid exactly 2 cycles after acceptance; lane0=-484, lane1=0, other lanes equal input; sat_flag=0.
2. Saturation: bias lane5=131000, input lane5=1000 → 131071 and sat_flag=1. Bias lane6=-131072, input -5 → -131072. Pulse sat_clr → flag 0. Clear coinciding with a new saturation → flag stays 1.
3. ReLU: same data as scenario 1 with relu=1 → lane0=0, lane1=0. A positive lane passes unchanged. A saturated-negative lane gives 0 and still sets sat_flag.
4. Backpressure: stream 5 vectors back-to-back, holding out_ready=0 for 3 cycles after the first output → out_data stable during the stall, in_ready=0 during the stall, all 5 outputs delivered in order with none lost or duplicated.
5. Collision: cfg_we to group 2 lane 0 (value 50, old value 10) in the same cycle as accepting a group-2 vector with lane0=0 → output lane0=10; the next group-2 vector gives 50.
6. Reset mid-stream: assert rst_n=0 with 2 vectors in flight → out_valid=0 the next cycle, no stale output afterwards, and a subsequent vector with any group gives out_data equal to in_data (biases zero).
